// File: rtl/uart_tx_arbiter.sv
// Packet-aware round-robin arbiter sharing one UART transmitter between two byte streams.
// An owner keeps the transmitter until a last byte, a burst limit, or an idle timeout.
module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned LOCK_TIMEOUT = 2048
) (
  input  logic       CP,
  input  logic       RST,
  input  logic       valid0,
  input  logic       valid1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       last0,
  input  logic       last1,
  output logic       ready0,
  output logic       ready1,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       gnt,
  output logic       busy,
  output logic       lock_drop
);

  localparam logic [7:0]  BurstMax    = 8'(MAX_BURST);
  localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        locked_q, locked_d;
  logic        owner_q, owner_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        lock_drop_q, lock_drop_d;

  logic        valid_own;
  logic        sel;

  always_ff @(posedge CP or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      locked_q    <= 1'b0;
      owner_q     <= 1'b0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b0;
      bcnt_q      <= 8'd0;
      tcnt_q      <= 16'd0;
      tx_data_q   <= 8'd0;
      tx_start_q  <= 1'b0;
      lock_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      locked_q    <= locked_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      bcnt_q      <= bcnt_d;
      tcnt_q      <= tcnt_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      lock_drop_q <= lock_drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    locked_d    = locked_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    bcnt_d      = bcnt_q;
    tcnt_d      = tcnt_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    lock_drop_d = 1'b0;

    valid_own = owner_q ? valid1 : valid0;
    // Pointer only breaks ties; a lone requester always wins.
    sel       = (valid0 && valid1) ? ptr_q : valid1;

    unique case (state_q)
      StIdle: begin
        if (locked_q) begin
          if (valid_own) begin
            state_d = StIssue;
            gnt_d   = owner_q;
            tcnt_d  = 16'd0;
          end else if (tcnt_q == TimeoutLast) begin
            locked_d    = 1'b0;
            bcnt_d      = 8'd0;
            tcnt_d      = 16'd0;
            ptr_d       = ~owner_q;
            lock_drop_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
        end else if (valid0 || valid1) begin
          state_d  = StIssue;
          locked_d = 1'b1;
          owner_d  = sel;
          gnt_d    = sel;
          bcnt_d   = 8'd0;
          tcnt_d   = 16'd0;
        end
      end
      StIssue: begin
        tx_data_d  = gnt_q ? data1 : data0;
        last_d     = gnt_q ? last1 : last0;
        tx_start_d = 1'b1;
        bcnt_d     = bcnt_q + 8'd1;
        state_d    = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!tx_busy) begin
          state_d = StIdle;
          if (last_q || (bcnt_q == BurstMax)) begin
            locked_d = 1'b0;
            ptr_d    = ~owner_q;
            bcnt_d   = 8'd0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ready0    = (state_q == StIssue) && !gnt_q;
  assign ready1    = (state_q == StIssue) && gnt_q;
  assign busy      = (state_q != StIdle);
  assign gnt       = gnt_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign lock_drop = lock_drop_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two instances (burst 16 and burst 2) share requester
// stimulus; each has a small transmitter model holding tx_busy for a fixed frame.
module tb_uart_tx_arbiter;

  localparam int Frame = 8;

  logic       CP;
  logic       RST;
  logic       valid0, valid1, last0, last1;
  logic [7:0] data0, data1;

  logic       a_ready0, a_ready1, a_tx_start, a_gnt, a_busy, a_lock_drop, a_tx_busy;
  logic [7:0] a_tx_data;
  logic       b_ready0, b_ready1, b_tx_start, b_gnt, b_busy, b_lock_drop, b_tx_busy;
  logic [7:0] b_tx_data;

  uart_tx_arbiter #(.MAX_BURST(16), .LOCK_TIMEOUT(50)) u_dut (
    .CP(CP), .RST(RST),
    .valid0(valid0), .valid1(valid1), .data0(data0), .data1(data1),
    .last0(last0), .last1(last1), .ready0(a_ready0), .ready1(a_ready1),
    .tx_data(a_tx_data), .tx_start(a_tx_start), .tx_busy(a_tx_busy),
    .gnt(a_gnt), .busy(a_busy), .lock_drop(a_lock_drop)
  );

  uart_tx_arbiter #(.MAX_BURST(2), .LOCK_TIMEOUT(50)) u_burst (
    .CP(CP), .RST(RST),
    .valid0(valid0), .valid1(valid1), .data0(data0), .data1(data1),
    .last0(last0), .last1(last1), .ready0(b_ready0), .ready1(b_ready1),
    .tx_data(b_tx_data), .tx_start(b_tx_start), .tx_busy(b_tx_busy),
    .gnt(b_gnt), .busy(b_busy), .lock_drop(b_lock_drop)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // Transmitter models: busy for Frame cycles starting the cycle after tx_start.
  int a_cnt = 0;
  int b_cnt = 0;
  always @(posedge CP) begin
    if (a_cnt != 0) a_cnt <= a_cnt - 1;
    else if (a_tx_start) a_cnt <= Frame;
    if (b_cnt != 0) b_cnt <= b_cnt - 1;
    else if (b_tx_start) b_cnt <= Frame;
  end
  assign a_tx_busy = (a_cnt != 0);
  assign b_tx_busy = (b_cnt != 0);

  // Logs of every tx_start pulse, lock_drop pulses and ready overlap.
  logic [7:0] a_log_d [256];
  logic       a_log_g [256];
  logic [7:0] b_log_d [256];
  logic       b_log_g [256];
  int a_n = 0;
  int b_n = 0;
  int a_drops = 0;
  int overlap = 0;
  always @(negedge CP) begin
    if (a_tx_start) begin
      a_log_d[a_n % 256] <= a_tx_data;
      a_log_g[a_n % 256] <= a_gnt;
      a_n <= a_n + 1;
    end
    if (b_tx_start) begin
      b_log_d[b_n % 256] <= b_tx_data;
      b_log_g[b_n % 256] <= b_gnt;
      b_n <= b_n + 1;
    end
    if (a_lock_drop) a_drops <= a_drops + 1;
    if ((a_ready0 && a_ready1) || (b_ready0 && b_ready1)) overlap <= overlap + 1;
  end

  // Requester byte queues: main writes entries and *_n, driver advances *_i.
  logic [7:0] q0_d [64];
  logic       q0_l [64];
  logic [7:0] q1_d [64];
  logic       q1_l [64];
  int q0_n = 0;
  int q1_n = 0;
  int q0_i = 0;
  int q1_i = 0;
  bit sel_b = 1'b0;

  initial begin
    bit t0, t1;
    valid0 = 1'b0; valid1 = 1'b0; data0 = 8'h00; data1 = 8'h00; last0 = 1'b0; last1 = 1'b0;
    forever begin
      @(negedge CP);
      t0 = valid0 && (sel_b ? b_ready0 : a_ready0);
      t1 = valid1 && (sel_b ? b_ready1 : a_ready1);
      @(posedge CP);
      #1;
      if (t0) q0_i++;
      if (t1) q1_i++;
      valid0 = (q0_i < q0_n);
      data0  = q0_d[q0_i % 64];
      last0  = q0_l[q0_i % 64];
      valid1 = (q1_i < q1_n);
      data1  = q1_d[q1_i % 64];
      last1  = q1_l[q1_i % 64];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push0(input logic l, input logic [7:0] d);
    q0_d[q0_n % 64] = d;
    q0_l[q0_n % 64] = l;
    q0_n++;
  endtask

  task automatic push1(input logic l, input logic [7:0] d);
    q1_d[q1_n % 64] = d;
    q1_l[q1_n % 64] = l;
    q1_n++;
  endtask

  task automatic end_reset(input int cycles);
    repeat (cycles) @(negedge CP);
    RST = 1'b1;
  endtask

  task automatic wait_quiet(input bit use_b, input string tag);
    bit done = 1'b0;
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge CP);
      n++;
      if (!(use_b ? b_busy : a_busy) && q0_i == q0_n && q1_i == q1_n) done = 1'b1;
    end
    check(tag, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int idle;
    bit seen;
    logic [7:0] exp_c [6];
    logic [7:0] exp_bd [7];
    logic       exp_bg [7];

    // Reset and first-byte latency.
    RST = 1'b0;
    push0(1'b1, 8'h7B);
    repeat (5) @(negedge CP);
    check("rst_tx_data", a_tx_data, 8'h00);
    check("rst_ctrl_a", {a_tx_start, a_ready0, a_ready1, a_gnt, a_busy, a_lock_drop}, 0);
    check("rst_ctrl_b", {b_tx_start, b_ready0, b_ready1, b_gnt, b_busy, b_lock_drop}, 0);
    RST = 1'b1;
    @(negedge CP);
    check("lat_ready", {a_ready0, a_ready1, a_busy, a_gnt, a_tx_start}, 5'b10100);
    @(negedge CP);
    check("lat_start", a_tx_start, 1);
    check("lat_data", a_tx_data, 8'h7B);
    @(negedge CP);
    check("start_one_cycle", a_tx_start, 0);
    wait_quiet(1'b0, "rst_quiet");

    // Contention with single-byte packets.
    @(negedge CP);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push0(1'b1, 8'h41);
      push1(1'b1, 8'h42);
    end
    end_reset(10);
    base = a_n;
    wait_quiet(1'b0, "cont_quiet");
    exp_c = '{8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h42};
    check("cont_count", a_n - base, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("cont_d%0d", i), a_log_d[(base + i) % 256], exp_c[i]);

    // Packet lock holds requester 0 through its packet.
    @(negedge CP);
    RST = 1'b0;
    push0(1'b0, 8'h10);
    push0(1'b0, 8'h11);
    push0(1'b1, 8'h12);
    push1(1'b1, 8'h55);
    end_reset(10);
    base = a_n;
    wait_quiet(1'b0, "pkt_quiet");
    check("pkt_count", a_n - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pkt_d%0d", i), a_log_d[(base + i) % 256], (i == 3) ? 8'h55 : 8'h10 + i);
      check($sformatf("pkt_g%0d", i), a_log_g[(base + i) % 256], (i == 3) ? 1 : 0);
    end

    // Burst limit of 2 on the second instance.
    @(negedge CP);
    RST = 1'b0;
    sel_b = 1'b1;
    for (int i = 0; i < 5; i++) push0(1'b0, 8'h20 + 8'(i));
    push1(1'b0, 8'h30);
    push1(1'b1, 8'h31);
    end_reset(10);
    base = b_n;
    wait_quiet(1'b1, "burst_quiet");
    exp_bd = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h22, 8'h23, 8'h24};
    exp_bg = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    check("burst_count", b_n - base, 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("burst_d%0d", i), b_log_d[(base + i) % 256], exp_bd[i]);
      check($sformatf("burst_g%0d", i), b_log_g[(base + i) % 256], exp_bg[i]);
    end

    // Lock timeout after a non-last byte.
    @(negedge CP);
    RST = 1'b0;
    sel_b = 1'b0;
    push0(1'b0, 8'h60);
    push1(1'b1, 8'h61);
    end_reset(12);
    base = a_n;
    begin
      int n = 0;
      while (a_n == base && n < 200) begin
        @(negedge CP);
        n++;
      end
    end
    check("to_first_byte", a_n - base, 1);
    base = a_drops;
    idle = 0;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge CP);
      if (!a_busy) idle++;
      if (a_lock_drop) seen = 1'b1;
    end
    check("to_seen", seen, 1);
    check("to_idle_cycles", idle, 51);
    @(negedge CP);
    check("to_drop_pulse", a_lock_drop, 0);
    check("to_grant1", {a_ready1, a_ready0, a_gnt}, 3'b101);
    wait_quiet(1'b0, "to_quiet");
    check("to_drop_count", a_drops - base, 1);
    check("to_last_data", a_log_d[(a_n - 1) % 256], 8'h61);

    // Reset while a frame is in flight.
    @(negedge CP);
    RST = 1'b0;
    push0(1'b1, 8'h77);
    end_reset(12);
    begin
      int n = 0;
      while (!a_tx_busy && n < 100) begin
        @(negedge CP);
        n++;
      end
    end
    @(negedge CP);
    check("mid_pre", {a_busy, a_tx_busy, a_tx_data}, {2'b11, 8'h77});
    RST = 1'b0;
    #1;
    check("mid_rst_ctrl", {a_busy, a_tx_start, a_ready0, a_ready1, a_gnt}, 0);
    check("mid_rst_data", a_tx_data, 8'h00);
    end_reset(2);
    base = a_n;
    repeat (40) @(negedge CP);
    check("mid_no_reissue", a_n - base, 0);
    check("mid_idle", a_busy, 0);

    check("ready_exclusive", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART transmitter between two byte-stream requesters, e.g. the echo path and a status/message generator. It performs packet-aware round-robin arbitration: a requester keeps the transmitter until it sends a byte marked `last`, reaches a burst limit, or times out. It issues exactly one `tx_start` per accepted byte and tracks the transmitter's `tx_busy` to know when the next byte may be issued.

## Interface
Parameters:
- `MAX_BURST`, default 16: maximum bytes one owner sends per grant before forced release; range 1..255.
- `LOCK_TIMEOUT`, default 2048: number of idle cycles a locked owner may leave `valid` low before its lock is dropped; range 1..65535.

Ports (one clock; reset asynchronous, active-low):
- `CP`  in  1  clock, rising edge.
- `RST`  in  1  asynchronous active-low reset.
- `valid0`, `valid1`  in  1  requester has a byte.
- `data0`, `data1`  in  8  byte to send.
- `last0`, `last1`  in  1  byte ends a packet.
- `ready0`, `ready1`  out  1  byte accepted this cycle.
- `tx_data`  out  8  byte to the transmitter.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_busy`  in  1  transmitter frame in progress.
- `gnt`  out  1  current/last granted requester index.
- `busy`  out  1  arbiter is not in IDLE.
- `lock_drop`  out  1  one-cycle pulse when a lock is released by timeout.

## Operation
- Requester rule: once `validN` is high, `validN`, `dataN` and `lastN` must be held stable until `readyN`. A byte transfers on the edge where `validN & readyN`.
- Internal state:
  - `ptr`: priority pointer, 1 bit.
  - `locked`: 1 bit.
  - `owner`: 1 bit.
  - `bcnt`: 8-bit burst counter.
  - `tcnt`: 16-bit timeout counter.
- FSM states are IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
- IDLE, `locked` set:
  - `valid[owner]` high: go to ISSUE with `gnt<=owner`; clear `tcnt`.
  - `valid[owner]` low: increment `tcnt`. The other requester is ignored.
  - `tcnt == LOCK_TIMEOUT-1` with `valid[owner]` still low: clear `locked` and `bcnt`, set `ptr<=~owner`, pulse `lock_drop`, stay in IDLE.
- IDLE, `locked` clear:
  - Only one valid: grant that requester.
  - Both valid: grant `ptr`.
  - Neither valid: stay in IDLE.
  - On a grant: `locked<=1`, `owner<=sel`, `gnt<=sel`, `bcnt<=0`, go to ISSUE.
- ISSUE (exactly 1 cycle): `ready[gnt]=1`. At the end edge:
  - `tx_data<=data[gnt]`, `tx_start<=1`.
  - `last_r<=last[gnt]`, `bcnt<=bcnt+1`.
  - Go to WAIT_BUSY.
- WAIT_BUSY: `tx_start` is high only in the first cycle of this state. Go to WAIT_DONE when `tx_busy==1`. The wait has no timeout; the transmitter must raise `tx_busy` after `tx_start`.
- WAIT_DONE: when `tx_busy==0`, go to IDLE. On that edge, if `last_r` or `bcnt==MAX_BURST`: `locked<=0`, `ptr<=~owner`, `bcnt<=0`. Otherwise the lock is kept.
- `tx_data` holds its value until the next ISSUE.
- `valid` changes on the non-granted requester never disturb an in-flight byte.
- Reset (asynchronous, at any state including mid-frame):
  - State returns to IDLE.
  - All outputs go to 0: `tx_data`=0x00, `tx_start`, `ready0/1`, `gnt`, `busy`, `lock_drop`.
  - `ptr`=0, `locked`=0, `bcnt`=0, `tcnt`=0.
  - No `tx_start` is issued for a byte that was pending at reset.

## Timing
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.
- Latency: `validN` high and sampled in IDLE at edge k gives `readyN` high during cycle k+1 and `tx_start` high during cycle k+2.
- Minimum spacing between successive `tx_start` pulses: the frame duration plus 3 cycles. At 104 cycles/bit and 10 bits, that is at least 1043 cycles.
- `busy` = (state != IDLE). `ready0 & ready1` is never high together.
- `lock_drop` pulses on the cycle after the timeout edge. `tcnt` counts only in IDLE while locked.
- `MAX_BURST=1` degenerates to per-byte round-robin.

## Test plan
- Reset: hold `RST=0` for 5 cycles, then release, with `valid0=1`, `data0`=0x7B (123). Required: all outputs 0 during reset; after release, `ready0` follows 1 cycle later and `tx_start` with `tx_data`=0x7B 1 cycle after that.
- Contention: both requesters valid from reset, each sending single-byte packets (`last`=1), `data0`=0x41 and `data1`=0x42, three each. Required: `tx_data` sequence 0x41, 0x42, 0x41, 0x42, 0x41, 0x42.
- Packet lock: requester 0 sends 0x10, 0x11, 0x12 with `last` on 0x12, while requester 1 is valid throughout. Required: all three bytes of requester 0 before any byte of requester 1; `gnt` stays 0 until the packet ends.
- Burst limit: `MAX_BURST=2`, requester 0 streams without `last`, requester 1 valid. Required: the pattern 0, 0, 1, … on `gnt` at the `tx_start` pulses.
- Timeout: `LOCK_TIMEOUT=50`; requester 0 sends one non-last byte, then drops `valid0`, while `valid1` stays high. Required: `lock_drop` pulses exactly once, 50 cycles after entering IDLE; requester 1 is granted next.
- Reset mid-frame: assert `RST` while in WAIT_DONE with `tx_busy` high. Required: state IDLE, `tx_start` stays 0, and no stale byte is reissued after release.
